// File: rtl/example_arbiter_if.sv
// Bundle of the requester-side and datapath-side signals of example_arbiter.
// slave is the arbiter's view of these signals; master is the view of the surrounding requesters and datapath.
interface example_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_offset;
  logic [8*NREQ-1:0] req_target;
  logic [NREQ-1:0]   ack;
  logic [7:0]        result;
  logic              timeout;
  logic              dp_start;
  logic [1:0]        dp_offset;
  logic [7:0]        dp_target;
  logic              dp_done;
  logic [7:0]        dp_variable;

  modport slave (
    input  req, req_offset, req_target, dp_done, dp_variable,
    output ack, result, timeout, dp_start, dp_offset, dp_target
  );

  modport master (
    output req, req_offset, req_target, dp_done, dp_variable,
    input  ack, result, timeout, dp_start, dp_offset, dp_target
  );
endinterface

// File: rtl/example_arbiter.sv
// Round-robin scheduler sharing one example datapath among NREQ requesters.
// Defining EXAMPLE_ARB_TIMEOUT_EN adds the WAIT abort timer.
//
// state  | meaning
// IDLE   | no job; arbitrate among req from ptr upward
// LAUNCH | dp_start pulse with operands of the granted requester
// WAIT   | wait for dp_done (or the abort timer)
// RESP   | ack[grant] pulse with result, advance ptr
module example_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  example_arbiter_if.slave   bus,
  output logic               busy,
  output logic [2:0]         arb_state
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 0 || TIMEOUT > 255) begin : g_param_check
    $error("example_arbiter: NREQ must be 2..8 and TIMEOUT 0..255");
  end

  state_t          state, state_next;
  logic [IW-1:0]   ptr, grant, pick;
  logic [IW:0]     idx;
  logic            found;
  logic            wait_tc, abort;
  logic [NREQ-1:0] ack_q;
  logic [7:0]      result_q, tgt_q;
  logic [1:0]      off_q;
  logic            timeout_q, busy_q, start_q;

  // First requester at or above ptr, wrapping at NREQ-1
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
      if (!found && bus.req[idx[IW-1:0]]) begin
        pick  = idx[IW-1:0];
        found = 1'b1;
      end
    end
  end

`ifdef EXAMPLE_ARB_TIMEOUT_EN
  // Loaded so terminal count lands on the TIMEOUT-th WAIT cycle
  localparam logic [7:0] TC_LOAD = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;
  logic [7:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!reset)                                wait_cnt <= '0;
    else if (state == LAUNCH)                  wait_cnt <= TC_LOAD;
    else if (state == WAIT && wait_cnt != '0)  wait_cnt <= wait_cnt - 8'd1;
  end

  assign wait_tc = (wait_cnt == 8'd0);
`else
  assign wait_tc = 1'b0;
`endif

  // dp_done has priority over the abort timer
  assign abort = (state == WAIT) && !bus.dp_done && wait_tc;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = LAUNCH;
      LAUNCH:  state_next = WAIT;
      WAIT:    if (bus.dp_done || wait_tc) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      ack_q     <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      off_q     <= '0;
      tgt_q     <= '0;
    end else begin
      state     <= state_next;
      busy_q    <= (state_next != IDLE);
      start_q   <= (state_next == LAUNCH);
      ack_q     <= (state_next == RESP) ? (NREQ'(1) << grant) : '0;
      timeout_q <= abort;
      if (state == IDLE && found) begin
        grant <= pick;
        off_q <= bus.req_offset[2*int'(pick) +: 2];
        tgt_q <= bus.req_target[8*int'(pick) +: 8];
      end
      if (state == WAIT && bus.dp_done) result_q <= bus.dp_variable;
      else if (abort)                   result_q <= 8'hFF;
      if (state == RESP) ptr <= (grant == IW'(NREQ-1)) ? '0 : grant + 1'b1;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.result    = result_q;
  assign bus.timeout   = timeout_q;
  assign bus.dp_start  = start_q;
  assign bus.dp_offset = off_q;
  assign bus.dp_target = tgt_q;
  assign busy          = busy_q;
  assign arb_state     = {1'b0, state};
endmodule

// File: tb/tb_example_arbiter.sv
// Bench for example_arbiter: job-timeline model checked every cycle plus directed literal checks.
module tb_example_arbiter;
  localparam int NREQ  = 4;
  localparam int TMO   = 20;
  localparam int NEVER = 1 << 30;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       busy;
  logic [2:0] arb_state;

  example_arbiter_if #(.NREQ(NREQ)) bus ();

  example_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .busy     (busy),
    .arb_state(arb_state)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Job timeline model: one job at a time, described by its launch and ack cycles
  bit         m_on     = 1'b0;
  int         m_idx    = 0;
  int         m_ptr    = 0;
  int         m_launch = NEVER;
  int         m_ack    = NEVER;
  logic [1:0] m_off    = '0;
  logic [7:0] m_tgt    = '0;
  logic [7:0] m_res    = '0;
  bit         m_to     = 1'b0;
  bit         m_got;
  int         m_i;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      m_on = 1'b0; m_ptr = 0; m_idx = 0;
      m_launch = NEVER; m_ack = NEVER;
      m_off = '0; m_tgt = '0; m_res = '0; m_to = 1'b0;
    end else if (!m_on) begin
      m_got = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        m_i = (m_ptr + k) % NREQ;
        if (!m_got && bus.req[m_i]) begin
          m_got = 1'b1;
          m_idx = m_i;
        end
      end
      if (m_got) begin
        m_on = 1'b1; m_launch = cyc; m_ack = NEVER; m_to = 1'b0;
        m_off = bus.req_offset[2*m_idx +: 2];
        m_tgt = bus.req_target[8*m_idx +: 8];
      end
    end else if (cyc - 1 == m_ack) begin
      m_on  = 1'b0;
      m_ptr = (m_idx + 1) % NREQ;
    end else if (cyc - 1 > m_launch && m_ack == NEVER) begin
      if (bus.dp_done) begin
        m_ack = cyc; m_res = bus.dp_variable; m_to = 1'b0;
      end
`ifdef EXAMPLE_ARB_TIMEOUT_EN
      else if (cyc - 1 - m_launch == TMO) begin
        m_ack = cyc; m_res = 8'hFF; m_to = 1'b1;
      end
`endif
    end
  end

  logic [NREQ-1:0] e_ack;
  logic [2:0]      e_state;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      e_ack   = (m_on && cyc == m_ack) ? (NREQ'(1) << m_idx) : '0;
      e_state = !m_on ? 3'd0 : (cyc == m_launch) ? 3'd1 : (cyc == m_ack) ? 3'd3 : 3'd2;
      chk("ack",       32'(bus.ack),       32'(e_ack));
      chk("busy",      32'(busy),          32'(m_on));
      chk("arb_state", 32'(arb_state),     32'(e_state));
      chk("dp_start",  32'(bus.dp_start),  32'(m_on && cyc == m_launch));
      chk("dp_offset", 32'(bus.dp_offset), 32'(m_off));
      chk("dp_target", 32'(bus.dp_target), 32'(m_tgt));
      chk("timeout",   32'(bus.timeout),   32'((e_ack != 0) && m_to));
      if (e_ack != 0) chk("result", 32'(bus.result), 32'(m_res));
    end
  end

  // Datapath stand-in: done pulses lat cycles after the start cycle (lat<0: never)
  int         lat       = -1;
  int         stray_cyc = NEVER;
  int         done_cyc  = NEVER;
  int         start_cyc = 0;
  logic [7:0] dp_val    = '0;

  always @(negedge clk) begin
    if (!reset) done_cyc = NEVER;
    else if (bus.dp_start) begin
      start_cyc = cyc;
      done_cyc  = (lat < 0) ? NEVER : cyc + lat;
    end
  end

  always @(posedge clk) begin
    #1;
    bus.dp_done     = (cyc == done_cyc) || (cyc == stray_cyc);
    bus.dp_variable = dp_val;
  end

  task automatic wait_ack(input bit drop, input int budget, output logic [NREQ-1:0] a,
                          output logic [7:0] r, output logic t, output int at);
    a = '0; r = '0; t = 1'b0; at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        a = bus.ack; r = bus.result; t = bus.timeout; at = cyc;
        if (drop) bus.req = bus.req & ~bus.ack;
        return;
      end
    end
    n_cmp++;
    n_fail++;
    $display("FAIL ack_wait: no ack within %0d cycles (cycle %0d)", budget, cyc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] a;
    logic [7:0]      r;
    logic            t;
    int              at, at1, req_cyc;

    for (int i = 0; i < NREQ; i++) begin
      bus.req_offset[2*i +: 2] = 2'(i);
      bus.req_target[8*i +: 8] = 8'(100 + 10*i);
    end
    bus.req = 4'b1111;

    // Reset held with every requester active
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack",       32'(bus.ack),       0);
    chk("rst_busy",      32'(busy),          0);
    chk("rst_state",     32'(arb_state),     0);
    chk("rst_result",    32'(bus.result),    0);
    chk("rst_dp_start",  32'(bus.dp_start),  0);
    chk("rst_dp_offset", 32'(bus.dp_offset), 0);
    chk("rst_dp_target", 32'(bus.dp_target), 0);
    chk("rst_timeout",   32'(bus.timeout),   0);
    @(posedge clk); #1;
    reset = 1'b1;
    lat   = 2;

    // Fairness: two rounds of all four requesting
    for (int rnd = 0; rnd < 2; rnd++) begin
      if (rnd == 1) bus.req = 4'b1111;
      for (int i = 0; i < NREQ; i++) begin
        dp_val = 8'(16*rnd + i + 1);
        wait_ack(1'b1, 40, a, r, t, at);
        chk("rr_order",  32'(a), 32'(1 << i));
        chk("rr_result", 32'(r), 32'(16*rnd + i + 1));
      end
    end

    // Single job, with a stray done during LAUNCH that must be ignored
    @(posedge clk); #1;
    lat = 10; dp_val = 8'h5A; req_cyc = cyc; stray_cyc = cyc + 1;
    bus.req = 4'b0100;
    wait_ack(1'b1, 40, a, r, t, at);
    chk("job_ack",       32'(a), 32'h4);
    chk("job_result",    32'(r), 32'h5A);
    chk("job_start_lat", 32'(start_cyc - req_cyc), 1);
    chk("job_ack_lat",   32'(at - start_cyc), 11);
    chk("job_dp_offset", 32'(bus.dp_offset), 2);
    chk("job_dp_target", 32'(bus.dp_target), 120);

    // Withdrawal during WAIT
    @(posedge clk); #1;
    lat = 10; dp_val = 8'h3C;
    bus.req = 4'b0010;
    repeat (4) @(posedge clk);
    #1 bus.req = '0;
    wait_ack(1'b1, 40, a, r, t, at);
    chk("wd_ack",    32'(a), 32'h2);
    chk("wd_result", 32'(r), 32'h3C);
    repeat (2) @(negedge clk);
    chk("wd_idle", 32'(arb_state), 0);

    // Reset in the middle of WAIT; ptr was 2, so requester 3 holds the job
    @(posedge clk); #1;
    lat = 30; dp_val = 8'hEE;
    bus.req = 4'b1010;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mr_in_wait",   32'(arb_state), 2);
    chk("mr_dp_offset", 32'(bus.dp_offset), 3);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mr_busy",  32'(busy), 0);
    chk("mr_ack",   32'(bus.ack), 0);
    chk("mr_state", 32'(arb_state), 0);
    @(posedge clk); #1;
    reset = 1'b1; lat = 3; dp_val = 8'h21;
    wait_ack(1'b1, 40, a, r, t, at);
    chk("mr_first_ack", 32'(a), 32'h2);
    chk("mr_first_res", 32'(r), 32'h21);
    dp_val = 8'h43;
    wait_ack(1'b1, 40, a, r, t, at);
    chk("mr_second_ack", 32'(a), 32'h8);
    chk("mr_second_res", 32'(r), 32'h43);

    // Top requester held continuously across the pointer wrap
    @(posedge clk); #1;
    lat = 1; dp_val = 8'h99;
    bus.req = 4'b1000;
    wait_ack(1'b0, 40, a, r, t, at1);
    chk("b2b_ack1", 32'(a), 32'h8);
    wait_ack(1'b1, 40, a, r, t, at);
    chk("b2b_ack2", 32'(a), 32'h8);
    chk("b2b_gap",  32'(at - at1), 4);

`ifdef EXAMPLE_ARB_TIMEOUT_EN
    @(posedge clk); #1;
    lat = -1;
    bus.req = 4'b0001;
    wait_ack(1'b1, 60, a, r, t, at);
    chk("to_ack",     32'(a), 32'h1);
    chk("to_flag",    32'(t), 1);
    chk("to_result",  32'(r), 32'hFF);
    chk("to_latency", 32'(at - start_cyc), 21);
    @(posedge clk); #1;
    lat = 20; dp_val = 8'h77;
    bus.req = 4'b0001;
    wait_ack(1'b1, 60, a, r, t, at);
    chk("lim_ack",     32'(a), 32'h1);
    chk("lim_flag",    32'(t), 0);
    chk("lim_result",  32'(r), 32'h77);
    chk("lim_latency", 32'(at - start_cyc), 21);
`else
    @(posedge clk); #1;
    lat = -1;
    bus.req = 4'b0001;
    repeat (40) @(negedge clk);
    chk("hold_state", 32'(arb_state), 2);
    chk("hold_busy",  32'(busy), 1);
    @(posedge clk); #1;
    reset = 1'b0; bus.req = '0;
    @(posedge clk); #1;
    reset = 1'b1;
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
